// File: rtl/mips_pkg.sv
// Shared MIPS datapath types and architectural register indices.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd0;
  localparam reg_idx_t REG_SP   = 5'd29;
  localparam reg_idx_t REG_RA   = 5'd31;

endpackage

// File: rtl/reg_read_port.sv
// One combinational register-file read port: 32:1 mux, $zero forcing and an
// optional write-through path enabled by the byp_en tie-off.
module reg_read_port
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W
) (
  input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0] regs,
  input  logic [ADDR_W-1:0]                  rd_addr,
  input  logic                               byp_en,
  input  logic                               wr_act,
  input  logic [ADDR_W-1:0]                  wr_addr,
  input  logic [DATA_W-1:0]                  wr_data,
  output logic [DATA_W-1:0]                  rd_data
);

  logic hit;

  // wr_act already excludes reset and index 0, so a hit is always a real write
  assign hit = byp_en && wr_act && (wr_addr == rd_addr);

  always_comb begin
    rd_data = regs[rd_addr];
    if (hit) begin
      rd_data = wr_data;
    end
    if (rd_addr == ADDR_W'(REG_ZERO)) begin
      rd_data = '0;
    end
  end

endmodule

// File: rtl/reg_file_32.sv
// Two-read/one-write MIPS register file with a debug read port.
// REG_FILE_BYPASS_EN enables write-through forwarding on read ports 1 and 2.
module reg_file_32
  import mips_pkg::*;
#(
  parameter int                 DATA_W  = mips_pkg::DATA_W,
  parameter int                 ADDR_W  = mips_pkg::ADDR_W,
  parameter int                 SP_IDX  = 29,
  parameter logic [DATA_W-1:0]  SP_INIT = 32'h0000_7FFC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [DATA_W-1:0] rd_data1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int NREG = 1 << ADDR_W;

  // Entry 0 has no storage; the read mux sees a constant zero in its place.
  logic [NREG-1:1][DATA_W-1:0] mem;
  logic [NREG-1:0][DATA_W-1:0] regs;
  logic                        wr_act;
  logic                        byp_en;

  assign wr_act = wr_en && !rst && (wr_addr != ADDR_W'(REG_ZERO));
  assign regs   = {mem, {DATA_W{1'b0}}};

`ifdef REG_FILE_BYPASS_EN
  assign byp_en = 1'b1;
`else
  assign byp_en = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem         <= '0;
      mem[SP_IDX] <= SP_INIT;
    end else if (wr_act) begin
      mem[wr_addr] <= wr_data;
    end
  end

  reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd1 (
    .regs    (regs),
    .rd_addr (rd_addr1),
    .byp_en  (byp_en),
    .wr_act  (wr_act),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_data (rd_data1)
  );

  reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd2 (
    .regs    (regs),
    .rd_addr (rd_addr2),
    .byp_en  (byp_en),
    .wr_act  (wr_act),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_data (rd_data2)
  );

  // Debug view always shows committed state, never the in-flight write
  reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dbg (
    .regs    (regs),
    .rd_addr (dbg_addr),
    .byp_en  (1'b0),
    .wr_act  (wr_act),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_data (dbg_data)
  );

endmodule

// File: tb/tb_reg_file_32.sv
// Directed self-checking bench for reg_file_32.
module tb_reg_file_32;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rd_addr1, rd_addr2, wr_addr, dbg_addr;
  logic [31:0] rd_data1, rd_data2, wr_data, dbg_data;
  logic        wr_en;

  int checks = 0;
  int errors = 0;

  always #50 clk = ~clk;

  reg_file_32 dut (
    .clk      (clk),
    .rst      (rst),
    .rd_addr1 (rd_addr1),
    .rd_data1 (rd_data1),
    .rd_addr2 (rd_addr2),
    .rd_data2 (rd_data2),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic sweep_reset_state(input string tag);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      check($sformatf("%s_dbg%0d", tag, i), dbg_data, (i == 29) ? 32'h0000_7FFC : 32'h0);
    end
  endtask

  logic [31:0] exp_byp;

  initial begin
    rst = 1'b1; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
    rd_addr1 = '0; rd_addr2 = '0; dbg_addr = '0;

    // Reset held with a pending write across two edges
    step();
    step();
    sweep_reset_state("rst");
    rst = 1'b0; wr_en = 1'b0;
    step();
    dbg_addr = 5'd5; #1;
    check("rst_lost_write", dbg_data, 32'h0);

    // Basic write/read
    wr(5'd8, 32'hAAAA_AAAA);
    wr(5'd9, 32'h5555_5555);
    rd_addr1 = 5'd8; rd_addr2 = 5'd9; #1;
    check("rd1_r8", rd_data1, 32'hAAAA_AAAA);
    check("rd2_r9", rd_data2, 32'h5555_5555);
    check("and_zero", rd_data1 & rd_data2, 32'h0);

    // $zero discards writes
    wr(5'd0, 32'hFFFF_FFFF);
    rd_addr1 = 5'd0; rd_addr2 = 5'd0; dbg_addr = 5'd0; #1;
    check("zero_rd1", rd_data1, 32'h0);
    check("zero_rd2", rd_data2, 32'h0);
    check("zero_dbg", dbg_data, 32'h0);

    // Same-cycle read of the write index
    wr(5'd12, 32'h0000_FFFF);
    rd_addr1 = 5'd12; rd_addr2 = 5'd12; dbg_addr = 5'd12;
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h1234_5678; #1;
`ifdef REG_FILE_BYPASS_EN
    exp_byp = 32'h1234_5678;
`else
    exp_byp = 32'h0000_FFFF;
`endif
    check("byp_rd1_pre", rd_data1, exp_byp);
    check("byp_rd2_pre", rd_data2, exp_byp);
    check("byp_dbg_pre", dbg_data, 32'h0000_FFFF);
    step();
    wr_en = 1'b0; #1;
    check("byp_rd1_post", rd_data1, 32'h1234_5678);
    check("byp_dbg_post", dbg_data, 32'h1234_5678);

    // Back-to-back writes to one index
    wr(5'd7, 32'h0000_0001);
    wr(5'd7, 32'h0000_0002);
    dbg_addr = 5'd7; #1;
    check("b2b_last_wins", dbg_data, 32'h0000_0002);

    // wr_en low across several edges
    wr(5'd3, 32'h3333_3333);
    wr_en = 1'b0; wr_addr = 5'd3; wr_data = 32'h0F0F_0F0F;
    repeat (4) step();
    dbg_addr = 5'd3; #1;
    check("wren0_hold", dbg_data, 32'h3333_3333);

    // Fill with index values, then pulse reset between edges
    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i));
    dbg_addr = 5'd31; rd_addr1 = 5'd17; rd_addr2 = 5'd29; #1;
    check("fill_dbg31", dbg_data, 32'd31);
    check("fill_rd1_17", rd_data1, 32'd17);
    check("fill_rd2_29", rd_data2, 32'd29);
    rst = 1'b1; #1;
    rst = 1'b0; #1;
    check("arst_rd1_17", rd_data1, 32'h0);
    check("arst_rd2_29", rd_data2, 32'h0000_7FFC);
    sweep_reset_state("arst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
